// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path.
package icache_pkg;

  localparam int unsigned ICACHE_BLOCK_BYTES = 64;
  localparam int unsigned ICACHE_BEAT_BITS   = 64;
  localparam int unsigned ICACHE_BEATS       = ICACHE_BLOCK_BYTES * 8 / ICACHE_BEAT_BITS;
  localparam int unsigned ICACHE_OFFSET_W    = 6;

  // Fixed encodings so the state can be compared against legacy code.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    RECV = ST_RECV,
    DONE = ST_DONE
  } refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Line-refill engine: one burst read per instruction miss, beats forwarded
// to the icache with one cycle of registered latency.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = ICACHE_BLOCK_BYTES,
  parameter int unsigned BEAT_BITS   = ICACHE_BEAT_BITS,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 InstrMissF,
  input  logic                 InstrCacheRepActive,
  input  logic [ADDR_W-1:0]    PCF,
  output logic                 MemReqValid,
  input  logic                 MemReqReady,
  output logic [ADDR_W-1:0]    MemReqAddr,
  input  logic                 MemRespValid,
  input  logic [BEAT_BITS-1:0] MemRespData,
  output logic                 RepReady,
  output logic [BEAT_BITS-1:0] RepWord,
  output logic                 RefillBusy
);

  localparam int unsigned BEATS = BLOCK_BYTES * 8 / BEAT_BITS;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Mask that clears the byte-offset bits of a fetch address.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(BLOCK_BYTES) - ADDR_W'(1));

  refill_state_t        state, state_next;
  logic [ADDR_W-1:0]    line_addr;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 rep_ready;
  logic [BEAT_BITS-1:0] rep_word;

  logic start_refill;
  logic req_fire;
  logic recv_beat;
  logic last_beat;

  assign start_refill = (state == IDLE) && InstrMissF && !InstrCacheRepActive;
  assign req_fire     = (state == REQ) && MemReqReady;
  // Beats outside RECV (stray responses) are dropped here.
  assign recv_beat    = (state == RECV) && MemRespValid;
  assign last_beat    = (beat_cnt == CNT_W'(BEATS - 1));

  // Next-state logic; a started refill always runs to completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_refill) state_next = REQ;
      REQ:  if (MemReqReady) state_next = RECV;
      RECV: if (recv_beat && last_beat) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, latched line address, beat counter and registered refill beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      line_addr <= '0;
      beat_cnt  <= '0;
      rep_ready <= 1'b0;
      rep_word  <= '0;
    end else begin
      state     <= state_next;
      rep_ready <= recv_beat;
      if (start_refill) line_addr <= PCF & LINE_MASK;
      if (recv_beat) rep_word <= MemRespData;
      if (req_fire) begin
        beat_cnt <= '0;
      end else if (recv_beat) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  assign MemReqValid = (state == REQ);
  assign MemReqAddr  = line_addr;
  assign RepReady    = rep_ready;
  assign RepWord     = rep_word;
  assign RefillBusy  = (state != IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus queues expected request
// addresses and refill beats, a monitor pops them as the DUT presents them.
module tb_icache_refill_ctrl;

  logic        clk;
  logic        reset;
  logic        InstrMissF;
  logic        InstrCacheRepActive;
  logic [31:0] PCF;
  logic        MemReqValid;
  logic        MemReqReady;
  logic [31:0] MemReqAddr;
  logic        MemRespValid;
  logic [63:0] MemRespData;
  logic        RepReady;
  logic [63:0] RepWord;
  logic        RefillBusy;

  icache_refill_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .InstrMissF          (InstrMissF),
    .InstrCacheRepActive (InstrCacheRepActive),
    .PCF                 (PCF),
    .MemReqValid         (MemReqValid),
    .MemReqReady         (MemReqReady),
    .MemReqAddr          (MemReqAddr),
    .MemRespValid        (MemRespValid),
    .MemRespData         (MemRespData),
    .RepReady            (RepReady),
    .RepWord             (RepWord),
    .RefillBusy          (RefillBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          busy_total = 0;
  logic        mon_armed = 1'b0;
  logic [63:0] exp_word_q[$];
  logic [31:0] exp_req_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d);
    MemRespValid = 1'b1;
    MemRespData  = d;
    exp_word_q.push_back(d);
    tick();
  endtask

  // Monitor: compares handshakes and refill beats against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_armed) begin
        if (MemReqValid === 1'b1 && MemReqReady === 1'b1) begin
          if (exp_req_q.size() == 0) chk("unexpected_req", {63'b0, MemReqValid}, 64'd0);
          else chk("req_addr", {32'b0, MemReqAddr}, {32'b0, exp_req_q.pop_front()});
        end
        if (RepReady !== 1'b0) begin
          if (exp_word_q.size() == 0) chk("unexpected_rep", {63'b0, RepReady}, 64'd0);
          else chk("rep_word", RepWord, exp_word_q.pop_front());
        end
        if (RefillBusy === 1'b1) busy_total++;
      end
    end
  end

  int busy0;

  initial begin
    reset = 1'b1;
    InstrMissF = 1'b0;
    InstrCacheRepActive = 1'b0;
    PCF = '0;
    MemReqReady = 1'b0;
    MemRespValid = 1'b0;
    MemRespData = '0;
    tick();
    tick();
    chk("rst_req_valid", {63'b0, MemReqValid}, 64'd0);
    chk("rst_req_addr", {32'b0, MemReqAddr}, 64'd0);
    chk("rst_rep_ready", {63'b0, RepReady}, 64'd0);
    chk("rst_rep_word", RepWord, 64'd0);
    chk("rst_busy", {63'b0, RefillBusy}, 64'd0);
    reset = 1'b0;
    mon_armed = 1'b1;

    // Basic refill, immediate grant, back-to-back beats.
    busy0 = busy_total;
    PCF = 32'h0000_1234;
    InstrMissF = 1'b1;
    MemReqReady = 1'b1;
    exp_req_q.push_back(32'h0000_1200);
    tick();
    chk("basic_req_valid", {63'b0, MemReqValid}, 64'd1);
    chk("basic_req_addr", {32'b0, MemReqAddr}, 64'h1200);
    InstrMissF = 1'b0;
    tick();
    chk("basic_req_drop", {63'b0, MemReqValid}, 64'd0);
    for (int i = 1; i <= 8; i++) beat(64'(i * 'h11));
    MemRespValid = 1'b0;
    chk("basic_done_ready", {63'b0, RepReady}, 64'd1);
    chk("basic_done_busy", {63'b0, RefillBusy}, 64'd1);
    tick();
    chk("basic_idle_busy", {63'b0, RefillBusy}, 64'd0);
    chk("basic_idle_ready", {63'b0, RepReady}, 64'd0);
    chk("basic_busy_cycles", 64'(busy_total - busy0), 64'd10);
    chk("basic_beats_left", 64'(exp_word_q.size()), 64'd0);

    // Grant stall with PCF changing, then gapped beats.
    MemReqReady = 1'b0;
    PCF = 32'h0000_1234;
    InstrMissF = 1'b1;
    tick();
    InstrMissF = 1'b0;
    PCF = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", {63'b0, MemReqValid}, 64'd1);
      chk("stall_req_addr", {32'b0, MemReqAddr}, 64'h1200);
      tick();
    end
    MemReqReady = 1'b1;
    exp_req_q.push_back(32'h0000_1200);
    chk("stall_grant_addr", {32'b0, MemReqAddr}, 64'h1200);
    tick();
    chk("stall_req_drop", {63'b0, MemReqValid}, 64'd0);
    for (int i = 0; i < 4; i++) beat(64'h00A0 + 64'(i));
    MemRespValid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("gap_rep_ready", {63'b0, RepReady}, 64'd0);
      chk("gap_rep_word", RepWord, 64'h00A3);
      chk("gap_busy", {63'b0, RefillBusy}, 64'd1);
    end
    for (int i = 4; i < 8; i++) beat(64'h00A0 + 64'(i));
    MemRespValid = 1'b0;
    chk("gap_done_ready", {63'b0, RepReady}, 64'd1);
    chk("gap_done_word", RepWord, 64'h00A7);
    tick();
    chk("gap_idle_busy", {63'b0, RefillBusy}, 64'd0);
    chk("gap_beats_left", 64'(exp_word_q.size()), 64'd0);

    // Stale miss held through DONE while the icache installs the line.
    PCF = 32'h0000_4078;
    InstrMissF = 1'b1;
    exp_req_q.push_back(32'h0000_4040);
    tick();
    chk("stale_req_addr", {32'b0, MemReqAddr}, 64'h4040);
    tick();
    for (int i = 0; i < 8; i++) beat(64'h00B0 + 64'(i));
    MemRespValid = 1'b0;
    InstrCacheRepActive = 1'b1;
    PCF = 32'h0000_5008;
    tick();
    chk("stale_idle_valid", {63'b0, MemReqValid}, 64'd0);
    chk("stale_idle_busy", {63'b0, RefillBusy}, 64'd0);
    tick();
    chk("stale_hold1_busy", {63'b0, RefillBusy}, 64'd0);
    tick();
    chk("stale_hold2_busy", {63'b0, RefillBusy}, 64'd0);
    InstrCacheRepActive = 1'b0;
    exp_req_q.push_back(32'h0000_5000);
    tick();
    chk("stale_new_valid", {63'b0, MemReqValid}, 64'd1);
    chk("stale_new_addr", {32'b0, MemReqAddr}, 64'h5000);

    // Reset in the middle of RECV.
    InstrMissF = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) beat(64'h00C0 + 64'(i));
    reset = 1'b1;
    MemRespValid = 1'b1;
    MemRespData = 64'h00C4;
    tick();
    chk("mid_rst_valid", {63'b0, MemReqValid}, 64'd0);
    chk("mid_rst_addr", {32'b0, MemReqAddr}, 64'd0);
    chk("mid_rst_ready", {63'b0, RepReady}, 64'd0);
    chk("mid_rst_word", RepWord, 64'd0);
    chk("mid_rst_busy", {63'b0, RefillBusy}, 64'd0);
    reset = 1'b0;

    // Stray beats while idle are dropped.
    MemRespData = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_rep_ready", {63'b0, RepReady}, 64'd0);
      chk("stray_rep_word", RepWord, 64'd0);
      chk("stray_busy", {63'b0, RefillBusy}, 64'd0);
    end
    MemRespValid = 1'b0;
    tick();

    chk("final_beats_left", 64'(exp_word_q.size()), 64'd0);
    chk("final_reqs_left", 64'(exp_req_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Line-refill engine directly upstream of the L1 instruction cache.
- On an instruction miss it issues one burst read for the 64-byte line containing PCF to the backing memory.
- Each 64-bit response beat is registered and forwarded to the cache as RepWord/RepReady.
- Replaces the temporary top-level RepReady/RepWord inputs; the top level then exposes the memory-side handshake instead.

Parameters:
- BLOCK_BYTES, 64, cache line size in bytes; must match icache B.
- BEAT_BITS, 64, data width of one refill beat.
- ADDR_W, 32, address width.
- BEATS (derived), BLOCK_BYTES*8/BEAT_BITS = 8, beats per line.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- InstrMissF  in  1  icache reports a fetch miss this cycle.
- InstrCacheRepActive  in  1  icache is installing a line.
- PCF  in  ADDR_W  fetch address of the missing instruction.
- MemReqValid  out  1  burst read request valid.
- MemReqReady  in  1  memory accepts the request.
- MemReqAddr  out  ADDR_W  line-aligned burst base address.
- MemRespValid  in  1  response beat valid.
- MemRespData  in  BEAT_BITS  response beat data.
- RepReady  out  1  one-cycle strobe: RepWord holds a valid beat.
- RepWord  out  BEAT_BITS  refill beat to the icache.
- RefillBusy  out  1  a refill is in progress (IDLE excluded).

Behaviour:
- Single clock domain; reset is synchronous, active-high, clock port clk, reset port reset.
- Reset values: state=IDLE, MemReqValid=0, MemReqAddr=0, RepReady=0, RepWord=0, RefillBusy=0, beat counter=0.
- States: IDLE, REQ, RECV, DONE.
- IDLE:
  - If InstrMissF=1 and InstrCacheRepActive=0, latch LineAddr = {PCF[ADDR_W-1:6], 6'b0} and go to REQ.
  - Otherwise stay in IDLE.
  - MemRespValid is ignored in IDLE, so stray beats are dropped.
- REQ:
  - MemReqValid=1 and MemReqAddr=LineAddr, both held stable until MemReqReady=1.
  - On the cycle MemReqValid & MemReqReady, go to RECV and clear the beat counter.
  - PCF changing while in REQ has no effect.
- RECV:
  - Each cycle with MemRespValid=1: RepWord <= MemRespData and RepReady <= 1 on the next cycle, so output latency is exactly 1 cycle.
  - The beat counter increments on each valid beat.
  - Beats arrive in linear order, beat 0 (lowest address) first; there is no reordering or critical-word-first.
  - Cycles without MemRespValid give RepReady=0 on the next cycle; RepWord holds its previous value.
  - On the valid beat when the counter == BEATS-1, go to DONE. The counter is 3 bits and wraps to 0 there.
  - A response beat accepted in the same cycle as the REQ handshake is not possible: memory latency is at least 1 cycle by contract.
- DONE:
  - Lasts 1 cycle; RepReady shows the final beat in this cycle. Then go to IDLE.
  - InstrMissF is ignored in DONE, because the icache miss is stale until the line installs.
- RefillBusy = 1 in REQ, RECV and DONE.
- Flushes and redirects do not abort a refill. The line always completes so the icache allocation stays consistent.
- Reset mid-refill:
  - Returns to IDLE next edge with all outputs at reset values.
  - A partially delivered line is abandoned; the icache is reset by the same reset.
- No backpressure from the icache: every RepReady beat is consumed.

Decomposition:
- Shared package icache_pkg holds:
  - refill_state_t enum (IDLE, REQ, RECV, DONE);
  - localparams ICACHE_BLOCK_BYTES=64, ICACHE_BEAT_BITS=64, ICACHE_BEATS=8, ICACHE_OFFSET_W=6.
- No sub-module: FSM, counter and output register stay in one module.

Test Plan:
- Basic refill:
  - Stimulus: reset 2 cycles, PCF=0x0000_1234, InstrMissF=1; memory grants immediately, returns beats 0x11..0x88 on consecutive cycles.
  - Response: MemReqAddr=0x0000_1200; 8 RepReady pulses, each one cycle after its MemRespValid, in order; DONE then IDLE; RefillBusy high 10 cycles.
- Grant stall:
  - Stimulus: hold MemReqReady=0 for 5 cycles; change PCF to 0x0000_2000 meanwhile.
  - Response: MemReqValid stays 1 and MemReqAddr stays 0x0000_1200 throughout; request accepted on cycle 6.
- Gapped beats:
  - Stimulus: insert 3 idle cycles between beats 3 and 4.
  - Response: RepReady=0 in those gaps and RepWord holds beat 3; total 8 pulses; DONE only after the 8th beat.
- Stale miss:
  - Stimulus: keep InstrMissF=1 through DONE, with InstrCacheRepActive=1 for 2 cycles after.
  - Response: no new request until InstrCacheRepActive=0; then a new REQ with the current PCF line address.
- Reset mid-RECV:
  - Stimulus: assert reset after beat 4.
  - Response: next cycle all outputs 0 and state IDLE; later MemRespValid beats produce no RepReady.
- Stray response:
  - Stimulus: MemRespValid=1 with data 0xDEAD while IDLE.
  - Response: RepReady stays 0 and RepWord is unchanged.
